// File: rtl/cache_pkg.sv
// Shared types and size helpers for the set-associative write-back cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SWAP_OUT = 2'd1,
      SWAP_IN  = 2'd2,
      FILL     = 2'd3
   } cache_state_e;

   typedef enum logic {
      POL_FIFO = 1'b0,
      POL_LRU  = 1'b1
   } policy_e;

   function automatic int line_size(input int line_addr_len);
      return 1 << line_addr_len;
   endfunction

   function automatic int set_size(input int set_addr_len);
      return 1 << set_addr_len;
   endfunction

   function automatic int way_addr_len(input int way_cnt);
      return (way_cnt > 1) ? $clog2(way_cnt) : 1;
   endfunction

endpackage

// File: rtl/cache_assoc_wb_if.sv
// CPU-side and line-wide memory-side signals of the cache, bundled as one bus.
interface cache_assoc_wb_if #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 6
);
   localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
   localparam int LINE_BITS    = 32 << LINE_ADDR_LEN;

   logic                    policy;
   logic [31:0]             addr;
   logic                    rd_req;
   logic                    wr_req;
   logic [31:0]             wr_data;
   logic [31:0]             rd_data;
   logic                    miss;
   logic [MEM_ADDR_LEN-1:0] mem_addr;
   logic                    mem_rd_req;
   logic                    mem_wr_req;
   logic [LINE_BITS-1:0]    mem_wr_line;
   logic [LINE_BITS-1:0]    mem_rd_line;
   logic                    mem_gnt;
   logic [31:0]             hit_cnt;
   logic [31:0]             miss_cnt;

   modport master (
      output policy, addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
      input  rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line, hit_cnt, miss_cnt
   );

   modport slave (
      input  policy, addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
      output rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line, hit_cnt, miss_cnt
   );

endinterface

// File: rtl/cache_repl.sv
// Per-set replacement state: FIFO pointers and LRU age permutations, plus victim choice.
module cache_repl
   import cache_pkg::*;
#(
   parameter int SET_ADDR_LEN = 3,
   parameter int WAY_CNT      = 4,
   localparam int WAL         = way_addr_len(WAY_CNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SET_ADDR_LEN-1:0] set,
   input  logic [WAL-1:0]          access_way,
   input  logic                    access_en,
   input  logic                    fill_en,
   input  policy_e                 policy,
   input  logic [WAY_CNT-1:0]      valid,
   output logic [WAL-1:0]          victim_way
);
   localparam int SETS = set_size(SET_ADDR_LEN);

   logic [WAL-1:0] fifo_ptr_reg [SETS];
   logic [WAL-1:0] age_reg      [SETS][WAY_CNT];
   logic [WAL-1:0] age_next     [WAY_CNT];
   logic [WAL-1:0] old_age;
   logic [WAL-1:0] lru_way;
   logic [WAL-1:0] invalid_way;
   logic           any_invalid;

   assign old_age = age_reg[set][access_way];

   // Accessed way becomes youngest; only ways younger than it age by one.
   for (genvar gi = 0; gi < WAY_CNT; gi++) begin : g_age
      assign age_next[gi] = (access_way == WAL'(gi))     ? '0 :
                            (age_reg[set][gi] < old_age) ? age_reg[set][gi] + WAL'(1) :
                                                           age_reg[set][gi];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            fifo_ptr_reg[s] <= '0;
            for (int w = 0; w < WAY_CNT; w++) age_reg[s][w] <= WAL'(w);
         end
      end else begin
         if (access_en || fill_en) begin
            for (int w = 0; w < WAY_CNT; w++) age_reg[set][w] <= age_next[w];
         end
         if (fill_en && valid[access_way] && (access_way == fifo_ptr_reg[set])) begin
            fifo_ptr_reg[set] <= fifo_ptr_reg[set] + WAL'(1);
         end
      end
   end

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      lru_way     = '0;
      invalid_way = '0;
      any_invalid = 1'b0;
      for (int w = WAY_CNT - 1; w >= 0; w--) begin
         if (!valid[w]) begin
            any_invalid = 1'b1;
            invalid_way = WAL'(w);
         end
         if (age_reg[set][w] == WAL'(WAY_CNT - 1)) lru_way = WAL'(w);
      end
   end

   assign victim_way = any_invalid          ? invalid_way :
                       (policy == POL_LRU)  ? lru_way     : fifo_ptr_reg[set];

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate data cache with FIFO/LRU replacement
// and hit/miss counters; line-wide memory port driven from the miss FSM.
module cache_assoc_wb
   import cache_pkg::*;
#(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 6,
   parameter int WAY_CNT       = 4
) (
   input logic             clk,
   input logic             rst,
   cache_assoc_wb_if.slave bus
);
   localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
   localparam int LINE_SIZE    = line_size(LINE_ADDR_LEN);
   localparam int SET_SIZE     = set_size(SET_ADDR_LEN);
   localparam int WAL          = way_addr_len(WAY_CNT);
   localparam int LINE_BITS    = 32 * LINE_SIZE;
   localparam int SET_LSB      = LINE_ADDR_LEN + 2;
   localparam int TAG_LSB      = SET_LSB + SET_ADDR_LEN;

   logic [LINE_ADDR_LEN-1:0] word;
   logic [SET_ADDR_LEN-1:0]  set;
   logic [TAG_ADDR_LEN-1:0]  tag;
   logic                     unused_addr;

   assign word        = bus.addr[SET_LSB-1:2];
   assign set         = bus.addr[TAG_LSB-1:SET_LSB];
   assign tag         = bus.addr[TAG_LSB+TAG_ADDR_LEN-1:TAG_LSB];
   assign unused_addr = ^{bus.addr[31:TAG_LSB+TAG_ADDR_LEN], bus.addr[1:0]};

   logic [LINE_BITS-1:0]    data_reg  [SET_SIZE][WAY_CNT];
   logic [TAG_ADDR_LEN-1:0] tag_reg   [SET_SIZE][WAY_CNT];
   logic [WAY_CNT-1:0]      valid_reg [SET_SIZE];
   logic [WAY_CNT-1:0]      dirty_reg [SET_SIZE];

   cache_state_e            state_reg;
   logic [SET_ADDR_LEN-1:0] fill_set_reg;
   logic [TAG_ADDR_LEN-1:0] fill_tag_reg;
   logic [WAL-1:0]          fill_way_reg;
   logic [MEM_ADDR_LEN-1:0] wb_addr_reg;
   logic [LINE_BITS-1:0]    wr_line_reg;
   logic [LINE_BITS-1:0]    line_buf_reg;
   logic [31:0]             rd_data_reg;
   logic [31:0]             hit_cnt_reg;
   logic [31:0]             miss_cnt_reg;

   logic [WAY_CNT-1:0] hit_vec;
   logic [WAL-1:0]     hit_way;
   logic               hit;
   logic               req;
   logic               idle_hit;
   logic               hit_write;
   logic [WAL-1:0]     victim_way;
   logic [SET_ADDR_LEN-1:0] repl_set;
   logic [WAL-1:0]     repl_way;
   logic [MEM_ADDR_LEN-1:0] mem_addr_mux;

   for (genvar gi = 0; gi < WAY_CNT; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[set][gi] && (tag_reg[set][gi] == tag);
   end

   always_comb begin
      hit_way = '0;
      for (int w = 0; w < WAY_CNT; w++) begin
         if (hit_vec[w]) hit_way = WAL'(w);
      end
   end

   assign hit       = |hit_vec;
   assign req       = bus.rd_req | bus.wr_req;
   assign idle_hit  = req && hit && (state_reg == IDLE);
   assign hit_write = idle_hit && !bus.rd_req && bus.wr_req;
   assign bus.miss  = req & ~(hit & (state_reg == IDLE));

   // During FILL the replacement state is updated for the latched line, not the live address.
   assign repl_set = (state_reg == FILL) ? fill_set_reg : set;
   assign repl_way = (state_reg == FILL) ? fill_way_reg : hit_way;

   cache_repl #(
      .SET_ADDR_LEN (SET_ADDR_LEN),
      .WAY_CNT      (WAY_CNT)
   ) u_repl (
      .clk        (clk),
      .rst        (rst),
      .set        (repl_set),
      .access_way (repl_way),
      .access_en  (idle_hit),
      .fill_en    (state_reg == FILL),
      .policy     (policy_e'(bus.policy)),
      .valid      (valid_reg[repl_set]),
      .victim_way (victim_way)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         fill_set_reg <= '0;
         fill_tag_reg <= '0;
         fill_way_reg <= '0;
         wb_addr_reg  <= '0;
         wr_line_reg  <= '0;
         line_buf_reg <= '0;
         rd_data_reg  <= '0;
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
         for (int s = 0; s < SET_SIZE; s++) begin
            valid_reg[s] <= '0;
            dirty_reg[s] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (idle_hit) begin
                  hit_cnt_reg <= hit_cnt_reg + 32'd1;
                  if (bus.rd_req) rd_data_reg <= data_reg[set][hit_way][{word, 5'b0} +: 32];
                  else            dirty_reg[set][hit_way] <= 1'b1;
               end else if (req) begin
                  fill_set_reg <= set;
                  fill_tag_reg <= tag;
                  fill_way_reg <= victim_way;
                  miss_cnt_reg <= miss_cnt_reg + 32'd1;
                  if (valid_reg[set][victim_way] && dirty_reg[set][victim_way]) begin
                     wr_line_reg <= data_reg[set][victim_way];
                     wb_addr_reg <= {tag_reg[set][victim_way], set};
                     state_reg   <= SWAP_OUT;
                  end else begin
                     state_reg   <= SWAP_IN;
                  end
               end
            end
            SWAP_OUT: if (bus.mem_gnt) state_reg <= SWAP_IN;
            SWAP_IN: begin
               if (bus.mem_gnt) begin
                  line_buf_reg <= bus.mem_rd_line;
                  state_reg    <= FILL;
               end
            end
            FILL: begin
               valid_reg[fill_set_reg][fill_way_reg] <= 1'b1;
               dirty_reg[fill_set_reg][fill_way_reg] <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Line and tag storage carry no reset; validity alone decides whether contents matter.
   always_ff @(posedge clk) begin
      if (hit_write) data_reg[set][hit_way][{word, 5'b0} +: 32] <= bus.wr_data;
      if (state_reg == FILL) begin
         data_reg[fill_set_reg][fill_way_reg] <= line_buf_reg;
         tag_reg[fill_set_reg][fill_way_reg]  <= fill_tag_reg;
      end
   end

   always_comb begin
      case (state_reg)
         SWAP_OUT: mem_addr_mux = wb_addr_reg;
         SWAP_IN:  mem_addr_mux = {fill_tag_reg, fill_set_reg};
         default:  mem_addr_mux = '0;
      endcase
   end

   assign bus.mem_addr    = mem_addr_mux;
   assign bus.mem_wr_req  = (state_reg == SWAP_OUT);
   assign bus.mem_rd_req  = (state_reg == SWAP_IN);
   assign bus.mem_wr_line = wr_line_reg;
   assign bus.rd_data     = rd_data_reg;
   assign bus.hit_cnt     = hit_cnt_reg;
   assign bus.miss_cnt    = miss_cnt_reg;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed plus randomized bench for cache_assoc_wb against a per-set cache model
// backed by a word-level memory image and a latency-programmable memory responder.
module tb_cache_assoc_wb;
   localparam int LA = 3;
   localparam int SA = 3;
   localparam int TA = 6;
   localparam int NW = 4;
   localparam int LW = 1 << LA;
   localparam int NS = 1 << SA;
   localparam int NL = 1 << (TA + SA);
   localparam int LB = 32 * LW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cache_assoc_wb_if #(.LINE_ADDR_LEN(LA), .SET_ADDR_LEN(SA), .TAG_ADDR_LEN(TA)) bus();

   cache_assoc_wb #(
      .LINE_ADDR_LEN (LA),
      .SET_ADDR_LEN  (SA),
      .TAG_ADDR_LEN  (TA),
      .WAY_CNT       (NW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] seed;
   int lat = 5;

   // Memory responder: grants after 'lat' cycles of a held request.
   logic [LB-1:0] bus_mem     [NL];
   bit            bus_written [NL];
   int            rcnt = 0;

   function automatic logic [31:0] init_word(input int la, input int k);
      return (32'(la) * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA77) ^ seed;
   endfunction

   function automatic logic [LB-1:0] init_line(input int la);
      logic [LB-1:0] r;
      for (int k = 0; k < LW; k++) r[k*32 +: 32] = init_word(la, k);
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst || !(bus.mem_rd_req || bus.mem_wr_req) || bus.mem_gnt) begin
         bus.mem_gnt <= 1'b0;
         rcnt        <= 0;
      end else if (rcnt >= lat - 1) begin
         bus.mem_gnt <= 1'b1;
         rcnt        <= 0;
         if (bus.mem_wr_req) begin
            bus_mem[bus.mem_addr]     <= bus.mem_wr_line;
            bus_written[bus.mem_addr] <= 1'b1;
         end else begin
            bus.mem_rd_line <= bus_written[bus.mem_addr] ? bus_mem[bus.mem_addr]
                                                         : init_line(int'(bus.mem_addr));
         end
      end else begin
         bus.mem_gnt <= 1'b0;
         rcnt        <= rcnt + 1;
      end
   end

   // Reference model: backing memory image plus per-set way contents and recency order.
   logic [31:0] ref_mem [NL][LW];
   logic        m_valid [NS][NW];
   logic        m_dirty [NS][NW];
   int          m_tag   [NS][NW];
   logic [31:0] m_data  [NS][NW][LW];
   int          m_fifo  [NS];
   int          m_order [NS][NW];
   logic [31:0] exp_hits;
   logic [31:0] exp_misses;

   task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      exp_hits   = 0;
      exp_misses = 0;
      for (int s = 0; s < NS; s++) begin
         m_fifo[s] = 0;
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_order[s][w] = w;
         end
      end
   endtask

   task automatic m_touch(input int s, input int v);
      int p = 0;
      for (int k = 0; k < NW; k++) if (m_order[s][k] == v) p = k;
      for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
      m_order[s][0] = v;
   endtask

   task automatic reset_checks();
      @(negedge clk);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_miss", bus.miss, 0);
      chk("rst_hit_cnt", bus.hit_cnt, 0);
      chk("rst_miss_cnt", bus.miss_cnt, 0);
      chk("rst_mem_rd_req", bus.mem_rd_req, 0);
      chk("rst_mem_wr_req", bus.mem_wr_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wr_line", bus.mem_wr_line, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      reset_checks();
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic pol);
      int s, t, wd, hw, v, cyc;
      logic wb_seen, rd_seen, exp_wb;
      logic [LB-1:0] exp_line;
      logic [31:0] exp_rd;
      t = int'(a[13:8]);
      s = int'(a[7:5]);
      wd = int'(a[4:2]);
      hw = -1;
      exp_wb = 1'b0;
      exp_line = '0;
      exp_rd = 32'h0;
      for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
      @(posedge clk); #1;
      bus.addr = a; bus.rd_req = rd; bus.wr_req = wr; bus.wr_data = d; bus.policy = pol;
      @(negedge clk);
      chk("miss_first", bus.miss, (hw < 0) ? 1 : 0);
      if (hw < 0) begin
         v = -1;
         for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
         if (v < 0) v = pol ? m_order[s][NW-1] : m_fifo[s];
         exp_wb = m_valid[s][v] && m_dirty[s][v];
         for (int k = 0; k < LW; k++) exp_line[k*32 +: 32] = m_data[s][v][k];
         exp_misses++;
         cyc = 0; wb_seen = 1'b0; rd_seen = 1'b0;
         while (bus.miss === 1'b1 && cyc < 200) begin
            if (bus.mem_wr_req === 1'b1 && !wb_seen) begin
               wb_seen = 1'b1;
               chk("wb_addr", bus.mem_addr, (m_tag[s][v] << SA) | s);
               chk("wb_line", bus.mem_wr_line, exp_line);
            end
            if (bus.mem_rd_req === 1'b1 && !rd_seen) begin
               rd_seen = 1'b1;
               chk("fetch_addr", bus.mem_addr, (t << SA) | s);
               chk("wb_before_fetch", wb_seen, exp_wb);
            end
            @(negedge clk);
            cyc++;
         end
         chk("miss_resolved", bus.miss, 0);
         chk("fetch_seen", rd_seen, 1);
         if (exp_wb) for (int k = 0; k < LW; k++) ref_mem[(m_tag[s][v] << SA) | s][k] = m_data[s][v][k];
         if (m_valid[s][v] && v == m_fifo[s]) m_fifo[s] = (m_fifo[s] + 1) % NW;
         m_valid[s][v] = 1'b1;
         m_dirty[s][v] = 1'b0;
         m_tag[s][v]   = t;
         for (int k = 0; k < LW; k++) m_data[s][v][k] = ref_mem[(t << SA) | s][k];
         m_touch(s, v);
         hw = v;
      end
      exp_hits++;
      m_touch(s, hw);
      if (rd) begin
         exp_rd = m_data[s][hw][wd];
      end else if (wr) begin
         m_data[s][hw][wd] = d;
         m_dirty[s][hw] = 1'b1;
      end
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      if (rd) chk("rd_data", bus.rd_data, exp_rd);
      chk("hit_cnt", bus.hit_cnt, exp_hits);
      chk("miss_cnt", bus.miss_cnt, exp_misses);
      $display("txn rd=%0b wr=%0b addr=%08h pol=%0b hit=%0b hits=%0d misses=%0d",
               rd, wr, a, pol, hw >= 0 && !exp_wb, exp_hits, exp_misses);
   endtask

   initial begin
      logic [31:0] a;
      int cyc;
      seed = $urandom;
      for (int l = 0; l < NL; l++) for (int k = 0; k < LW; k++) ref_mem[l][k] = init_word(l, k);
      bus.policy = 1'b0; bus.addr = '0; bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.wr_data = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_checks();

      lat = 5;
      do_req(1'b1, 1'b0, 32'h0000, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 32'h0104, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 1'b0, 32'h0104, 32'h0, 1'b0);

      lat = 2;
      do_reset();
      do_req(1'b0, 1'b1, 32'h0000, $urandom, 1'b0);
      do_req(1'b1, 1'b0, 32'h0100, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0200, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0300, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0400, 32'h0, 1'b0);

      do_reset();
      do_req(1'b0, 1'b1, 32'h0000, $urandom, 1'b1);
      do_req(1'b1, 1'b0, 32'h0100, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h0200, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h0300, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h0000, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h0400, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h0000, 32'h0, 1'b1);
      do_req(1'b1, 1'b1, 32'h0000, 32'h12345678, 1'b1);
      do_req(1'b1, 1'b0, 32'h0000, 32'h0, 1'b1);

      // Abort a fetch in SWAP_IN with reset; the dirty line at 0x000 is lost.
      lat = 5;
      do_reset();
      do_req(1'b0, 1'b1, 32'h0000, $urandom, 1'b0);
      @(posedge clk); #1;
      bus.addr = 32'h0500; bus.rd_req = 1'b1; bus.wr_req = 1'b0; bus.policy = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (bus.mem_rd_req !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("swapin_reached", bus.mem_rd_req, 1);
      rst = 1'b1;
      #1;
      chk("abort_mem_rd_req", bus.mem_rd_req, 0);
      chk("abort_mem_addr", bus.mem_addr, 0);
      chk("abort_hit_cnt", bus.hit_cnt, 0);
      chk("abort_miss_cnt", bus.miss_cnt, 0);
      bus.rd_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      do_req(1'b1, 1'b0, 32'h0500, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0000, 32'h0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         int op;
         lat = $urandom_range(1, 4);
         op = $urandom_range(0, 3);
         a = $urandom;
         a[13:8] = 6'($urandom_range(0, 7));
         a[7:5]  = 3'($urandom_range(0, 1));
         do_req(op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
